sliding_window_ctrl: RTL and testbench
======================================

Name: sliding_window_ctrl

Overview:
- Frame-level sequencer for the k×k sliding-window line buffer. The window datapath advances on every clock and has no enable, so this block supplies it with an uninterrupted pixel stream.
- Takes a valid/ready pixel stream with start-of-frame marking and tracks the raster position of every pixel.
- Clears the window between frames and on stream faults.
- Flags the cycles where the window holds a fully in-image neighbourhood, for the downstream convolution stage.

Parameters:
KERNEL_SIZE, 3, window edge length (odd, ≥3)
ROW_WIDTH, 640, pixels per row; must match the window instance
NUM_ROWS, 480, rows per frame

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
enable  in  1  level; run frames while high
clear_err  in  1  pulse; clears sticky error flags
in_valid  in  1  upstream pixel valid
in_sof  in  1  marks first pixel of frame (qualified by in_valid)
in_pixel  in  8  upstream pixel
in_ready  out  1  upstream may transfer
win_pixel  out  8  pixel to window pixel_in
win_clear  out  1  active-high clear to the window reset input
out_valid  out  1  window contents are a complete in-image neighbourhood
out_row  out  $clog2(NUM_ROWS)  centre row of current window
out_col  out  $clog2(ROW_WIDTH)  centre column of current window
frame_done  out  1  one-cycle pulse, coincident with last out_valid of frame
busy  out  1  state != IDLE
err_underrun  out  1  sticky: in_valid gap mid-frame
err_sof  out  1  sticky: unexpected in_sof mid-frame
frame_count  out  16  completed frames, wraps at 2^16

Behaviour:
- Reset (reset==0 at a clock edge):
  - state = IDLE; counters = 0; frame_count = 0; error flags = 0.
  - out_valid = 0, frame_done = 0, out_row/out_col = 0.
  - Reset mid-frame aborts the frame with no frame_done.
- FSM states: IDLE, WAIT_SOF, STREAM, DONE.
  - IDLE: in_ready = 0, win_clear = 1. Goes to WAIT_SOF when enable = 1.
  - WAIT_SOF: in_ready = 1.
    - Beats without in_sof are dropped, and win_clear = 1 on those cycles.
    - A beat with in_valid & in_sof is accepted as pixel (0,0) with win_clear = 0; go to STREAM.
    - enable = 0 → IDLE.
  - STREAM: in_ready = 1, win_clear = 0, one pixel accepted per cycle.
    - in_valid = 0 → set err_underrun, win_clear = 1 that cycle, go to WAIT_SOF.
    - in_valid & in_sof → set err_sof, drop the pixel, win_clear = 1, go to WAIT_SOF.
    - Acceptance of pixel (NUM_ROWS-1, ROW_WIDTH-1) → DONE.
  - DONE (one cycle): in_ready = 0, win_clear = 1, frame_count += 1. Next state is WAIT_SOF if enable = 1, else IDLE.
- enable only affects IDLE/WAIT_SOF/DONE; a frame in STREAM always completes.
- Datapath:
  - win_pixel = in_pixel (combinational).
  - The window captures in_pixel on the same edge the beat is accepted.
- Raster counters col/row:
  - Advance on every accepted pixel.
  - col wraps ROW_WIDTH-1 → 0 and increments row at the wrap.
  - Both reset to 0 when entering WAIT_SOF.
- Output timing (registered, 1 cycle after acceptance of pixel (r,c)):
  - out_valid = (r ≥ K-1) && (c ≥ K-1), with K = KERNEL_SIZE.
  - out_row = r-(K-1)/2, out_col = c-(K-1)/2.
  - Otherwise out_valid = 0, and out_row/out_col hold their last value.
- frame_done is registered together with the out_valid of the final pixel. It therefore fires in the cycle the FSM is in DONE.
- Error flags:
  - Sticky until clear_err or reset.
  - If clear_err and a new error occur in the same cycle, the set wins.
- Aborted frames: no frame_done, and frame_count is not incremented.

Decomposition:
- Package sliding_window_pkg:
  - PIXEL_W = 8.
  - ctrl_state_t enum {IDLE, WAIT_SOF, STREAM, DONE}.
  - Default KERNEL_SIZE, ROW_WIDTH, NUM_ROWS.
- One sub-module, raster_counter:
  - Parameterised col/row counter.
  - Ports: inc, clr, col, row, last (high at the final pixel).

Test Plan:
- Reset held low 3 cycles mid-STREAM, then released → all outputs 0, state IDLE, frame_count = 0.
- Run a full frame with ROW_WIDTH=8, NUM_ROWS=6, K=3, gap-free → 24 out_valid pulses with centres (1..4, 1..6). frame_done coincides with (4,6). frame_count = 1.
- Send 5 non-sof beats, then sof → first 5 dropped with win_clear high. Pixel (0,0) is accepted on the sof beat.
- Drop in_valid for one cycle at pixel (2,3) → err_underrun = 1, win_clear pulse, return to WAIT_SOF. No frame_done, frame_count unchanged.
- Assert in_sof at pixel (1,0) → err_sof = 1 and the pixel is dropped. A clean frame then completes; assert clear_err → err_sof = 0.
- Deassert enable during STREAM → the current frame completes with frame_done, then state goes to IDLE and in_ready = 0.

Source files
------------

// File: rtl/sliding_window_pkg.sv
// Shared types and defaults for the sliding-window frame sequencer.
package sliding_window_pkg;

    localparam int unsigned PIXEL_W          = 8;
    localparam int unsigned DEF_KERNEL_SIZE  = 3;
    localparam int unsigned DEF_ROW_WIDTH    = 640;
    localparam int unsigned DEF_NUM_ROWS     = 480;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOF,
        STREAM,
        DONE
    } ctrl_state_t;

endpackage

// File: rtl/sliding_window_ctrl_if.sv
// Upstream valid/ready pixel stream with start-of-frame marking.
interface sliding_window_ctrl_if;
    import sliding_window_pkg::*;

    logic               in_valid;
    logic               in_sof;
    logic [PIXEL_W-1:0] in_pixel;
    logic               in_ready;

    modport master (output in_valid, output in_sof, output in_pixel, input in_ready);
    modport slave  (input in_valid, input in_sof, input in_pixel, output in_ready);

endinterface

// File: rtl/raster_counter.sv
// Column/row raster position counter; last flags the final pixel of a frame.
module raster_counter
    import sliding_window_pkg::*;
#(
    parameter int unsigned ROW_WIDTH = DEF_ROW_WIDTH,
    parameter int unsigned NUM_ROWS  = DEF_NUM_ROWS,
    localparam int unsigned COL_W    = $clog2(ROW_WIDTH),
    localparam int unsigned ROW_W    = $clog2(NUM_ROWS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last
);

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(ROW_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(NUM_ROWS - 1);

    assign last = (col == COL_MAX) && (row == ROW_MAX);

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            col <= '0;
            row <= '0;
        end else if (inc) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sliding_window_ctrl.sv
// Frame sequencer feeding a free-running k x k window: accepts a gap-free
// pixel stream, clears the window between frames/faults and flags full neighbourhoods.
module sliding_window_ctrl
    import sliding_window_pkg::*;
#(
    parameter int unsigned KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int unsigned ROW_WIDTH   = DEF_ROW_WIDTH,
    parameter int unsigned NUM_ROWS    = DEF_NUM_ROWS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          clear_err,
    sliding_window_ctrl_if.slave          up,
    output logic [PIXEL_W-1:0]            win_pixel,
    output logic                          win_clear,
    output logic                          out_valid,
    output logic [$clog2(NUM_ROWS)-1:0]   out_row,
    output logic [$clog2(ROW_WIDTH)-1:0]  out_col,
    output logic                          frame_done,
    output logic                          busy,
    output logic                          err_underrun,
    output logic                          err_sof,
    output logic [15:0]                   frame_count
);

    localparam int unsigned COL_W = $clog2(ROW_WIDTH);
    localparam int unsigned ROW_W = $clog2(NUM_ROWS);
    localparam int unsigned HALF  = (KERNEL_SIZE - 1) / 2;

    ctrl_state_t      state, state_nxt;
    logic             accept;
    logic             fault_underrun;
    logic             fault_sof;
    logic             cnt_clr;
    logic             last;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    assign win_pixel = up.in_pixel;

    // The window has no enable, so win_clear must follow the current beat
    // combinationally: any cycle that does not deliver a pixel clears it.
    always_comb begin
        accept         = 1'b0;
        fault_underrun = 1'b0;
        fault_sof      = 1'b0;
        win_clear      = 1'b1;
        case (state)
            WAIT_SOF: begin
                accept    = up.in_valid & up.in_sof;
                win_clear = ~accept;
            end
            STREAM: begin
                fault_underrun = ~up.in_valid;
                fault_sof      = up.in_valid & up.in_sof;
                accept         = up.in_valid & ~up.in_sof;
                win_clear      = ~accept;
            end
            default: ;
        endcase
        cnt_clr = (state == IDLE) || (state == DONE) || fault_underrun || fault_sof;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (enable) state_nxt = WAIT_SOF;
            WAIT_SOF: begin
                if (accept)       state_nxt = STREAM;
                else if (!enable) state_nxt = IDLE;
            end
            STREAM: begin
                if (fault_underrun || fault_sof) state_nxt = WAIT_SOF;
                else if (accept && last)         state_nxt = DONE;
            end
            DONE:     state_nxt = enable ? WAIT_SOF : IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            up.in_ready <= 1'b0;
            busy        <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= state_nxt;
            up.in_ready <= (state_nxt == WAIT_SOF) || (state_nxt == STREAM);
            busy        <= (state_nxt != IDLE);
            if (state == DONE) frame_count <= frame_count + 16'd1;
        end
    end

    raster_counter #(
        .ROW_WIDTH (ROW_WIDTH),
        .NUM_ROWS  (NUM_ROWS)
    ) u_raster (
        .clk   (clk),
        .reset (reset),
        .inc   (accept),
        .clr   (cnt_clr),
        .col   (col),
        .row   (row),
        .last  (last)
    );

    // Centre coordinates are registered from the pre-increment raster position.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            out_row    <= '0;
            out_col    <= '0;
        end else begin
            out_valid  <= accept && (row >= ROW_W'(KERNEL_SIZE - 1))
                                 && (col >= COL_W'(KERNEL_SIZE - 1));
            frame_done <= accept && last;
            if (accept && (row >= ROW_W'(KERNEL_SIZE - 1))
                       && (col >= COL_W'(KERNEL_SIZE - 1))) begin
                out_row <= row - ROW_W'(HALF);
                out_col <= col - COL_W'(HALF);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_underrun <= 1'b0;
            err_sof      <= 1'b0;
        end else begin
            if (fault_underrun)  err_underrun <= 1'b1;
            else if (clear_err)  err_underrun <= 1'b0;
            if (fault_sof)       err_sof <= 1'b1;
            else if (clear_err)  err_sof <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sliding_window_ctrl.sv
// Bench for sliding_window_ctrl on an 8x6 frame with a 3x3 kernel.
module tb_sliding_window_ctrl;
    import sliding_window_pkg::*;

    localparam int W = 8;
    localparam int R = 6;
    localparam int K = 3;

    typedef struct {
        int ov;
        int fd;
        int r;
        int c;
    } exp_t;

    typedef struct {
        logic       en;
        logic       v;
        logic       sof;
        logic [7:0] px;
        logic       rdy;
        logic       clr;
        logic       busy_after;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        clear_err;
    logic [7:0]  win_pixel;
    logic        win_clear;
    logic        out_valid;
    logic [2:0]  out_row;
    logic [2:0]  out_col;
    logic        frame_done;
    logic        busy;
    logic        err_underrun;
    logic        err_sof;
    logic [15:0] frame_count;

    sliding_window_ctrl_if s_if ();

    sliding_window_ctrl #(
        .KERNEL_SIZE (K),
        .ROW_WIDTH   (W),
        .NUM_ROWS    (R)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .clear_err    (clear_err),
        .up           (s_if),
        .win_pixel    (win_pixel),
        .win_clear    (win_clear),
        .out_valid    (out_valid),
        .out_row      (out_row),
        .out_col      (out_col),
        .frame_done   (frame_done),
        .busy         (busy),
        .err_underrun (err_underrun),
        .err_sof      (err_sof),
        .frame_count  (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total  = 0;
    int   passed = 0;
    int   ov_seen = 0;
    exp_t exp_q[$];
    exp_t none = '{default: 0};
    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act == expv) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    task automatic pop_check();
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_valid", out_valid, e.ov);
            chk("frame_done", frame_done, e.fd);
            if (e.ov != 0) begin
                chk("out_row", out_row, e.r);
                chk("out_col", out_col, e.c);
            end
        end else begin
            chk("out_valid_quiet", out_valid, 0);
            chk("frame_done_quiet", frame_done, 0);
        end
        if (out_valid) ov_seen++;
    endtask

    // Drive one beat, compare at the falling edge, then advance one clock.
    task automatic step(input logic v, input logic sof, input logic [7:0] px,
                        input bit push, input exp_t e,
                        input logic exp_rdy, input logic exp_clr);
        s_if.in_valid = v;
        s_if.in_sof   = sof;
        s_if.in_pixel = px;
        @(negedge clk);
        pop_check();
        chk("in_ready", s_if.in_ready, exp_rdy);
        chk("win_clear", win_clear, exp_clr);
        if (v) chk("win_pixel", win_pixel, px);
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixels(input int first, input int last_i, input bit sof_first);
        for (int i = first; i <= last_i; i++) begin
            int   r;
            int   c;
            exp_t e;
            r    = i / W;
            c    = i % W;
            e.ov = (r >= K - 1 && c >= K - 1) ? 1 : 0;
            e.r  = r - (K - 1) / 2;
            e.c  = c - (K - 1) / 2;
            e.fd = (r == R - 1 && c == W - 1) ? 1 : 0;
            step(1'b1, sof_first && (i == first), 8'(i * 7 + 3), 1'b1, e, 1'b1, 1'b0);
        end
    endtask

    initial begin
        vecs[0] = '{en: 1'b0, v: 1'b0, sof: 1'b0, px: 8'h00, rdy: 1'b0, clr: 1'b1, busy_after: 1'b0};
        vecs[1] = '{en: 1'b1, v: 1'b1, sof: 1'b0, px: 8'h11, rdy: 1'b0, clr: 1'b1, busy_after: 1'b1};
        vecs[2] = '{en: 1'b1, v: 1'b1, sof: 1'b0, px: 8'h21, rdy: 1'b1, clr: 1'b1, busy_after: 1'b1};
        vecs[3] = '{en: 1'b1, v: 1'b1, sof: 1'b0, px: 8'h32, rdy: 1'b1, clr: 1'b1, busy_after: 1'b1};
        vecs[4] = '{en: 1'b1, v: 1'b1, sof: 1'b0, px: 8'h43, rdy: 1'b1, clr: 1'b1, busy_after: 1'b1};
        vecs[5] = '{en: 1'b1, v: 1'b1, sof: 1'b0, px: 8'h54, rdy: 1'b1, clr: 1'b1, busy_after: 1'b1};
        vecs[6] = '{en: 1'b1, v: 1'b1, sof: 1'b0, px: 8'h65, rdy: 1'b1, clr: 1'b1, busy_after: 1'b1};
        vecs[7] = '{en: 1'b1, v: 1'b1, sof: 1'b1, px: 8'h03, rdy: 1'b1, clr: 1'b0, busy_after: 1'b1};

        reset         = 1'b0;
        enable        = 1'b0;
        clear_err     = 1'b0;
        s_if.in_valid = 1'b0;
        s_if.in_sof   = 1'b0;
        s_if.in_pixel = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Partial frame reaching centre (1,3), then reset held low 3 cycles mid-stream.
        enable = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b0, none, 1'b0, 1'b1);
        send_pixels(0, 20, 1'b1);
        reset  = 1'b0;
        enable = 1'b0;
        s_if.in_valid = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_out_col", out_col, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", s_if.in_ready, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_err_underrun", err_underrun, 0);
        chk("rst_err_sof", err_sof, 0);
        chk("rst_win_clear", win_clear, 1);

        // Table: IDLE, enable, five dropped non-sof beats, then the sof beat as pixel (0,0).
        ov_seen = 0;
        for (int i = 0; i < 8; i++) begin
            enable = vecs[i].en;
            step(vecs[i].v, vecs[i].sof, vecs[i].px, 1'b0, none, vecs[i].rdy, vecs[i].clr);
            chk("vec_busy", busy, vecs[i].busy_after);
        end
        send_pixels(1, W * R - 1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, none, 1'b0, 1'b1);
        chk("frame1_count", frame_count, 1);
        chk("frame1_ov_pulses", ov_seen, 24);

        // Underrun at (2,3) with clear_err high in the same cycle: the set wins.
        send_pixels(0, 2 * W + 2, 1'b1);
        clear_err = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b0, none, 1'b1, 1'b1);
        clear_err = 1'b0;
        chk("underrun_flag", err_underrun, 1);
        chk("underrun_busy", busy, 1);
        chk("underrun_ready", s_if.in_ready, 1);
        step(1'b0, 1'b0, 8'h00, 1'b0, none, 1'b1, 1'b1);
        chk("underrun_count", frame_count, 1);
        clear_err = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b0, none, 1'b1, 1'b1);
        clear_err = 1'b0;
        chk("underrun_cleared", err_underrun, 0);

        // Stray sof at (1,0): pixel dropped, back to WAIT_SOF, then a clean frame.
        send_pixels(0, W - 1, 1'b1);
        step(1'b1, 1'b1, 8'hA5, 1'b0, none, 1'b1, 1'b1);
        chk("sof_flag", err_sof, 1);
        chk("sof_ready", s_if.in_ready, 1);
        chk("sof_underrun_clear", err_underrun, 0);
        ov_seen = 0;
        send_pixels(0, W * R - 1, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0, none, 1'b0, 1'b1);
        chk("frame2_count", frame_count, 2);
        chk("frame2_ov_pulses", ov_seen, 24);
        chk("sof_sticky", err_sof, 1);
        clear_err = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b0, none, 1'b1, 1'b1);
        clear_err = 1'b0;
        chk("sof_cleared", err_sof, 0);

        // Enable dropped mid-frame: the frame still completes, then IDLE.
        ov_seen = 0;
        send_pixels(0, 9, 1'b1);
        enable = 1'b0;
        send_pixels(10, W * R - 1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, none, 1'b0, 1'b1);
        chk("frame3_count", frame_count, 3);
        chk("frame3_ov_pulses", ov_seen, 24);
        chk("idle_busy", busy, 0);
        chk("idle_ready", s_if.in_ready, 0);
        step(1'b1, 1'b1, 8'h77, 1'b0, none, 1'b0, 1'b1);
        chk("idle_stays", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
